agc_muldiv_unit: RTL and testbench

- Iterative multiply/divide engine for the AGC datapath: the responder side of the controller's MP0/MP1 and DV0/DV1 ALU ops.
- The controller pulses start with the op code. The unit runs a shift-add (MP) or restoring shift-subtract (DV) on ones' complement words and raises done.
- The controller then writes hi_out into A and lo_out into LP/L.
- Sits beside the combinational AD/SU/MASK ALU; shares the X/Y/A/L operand buses.

---
 rtl/agc_muldiv_unit_pkg.sv | 29 ++
 rtl/agc_muldiv_unit_if.sv | 40 ++++
 rtl/agc_muldiv_unit_ones_comp_mag.sv | 18 +
 rtl/agc_muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_agc_muldiv_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/agc_muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// agc_pkg : shared definitions for the AGC ALU blocks.
//   - ALU op codes (AD/SU/MASK are handled by the combinational ALU,
//     MP0/DV0 start the iterative multiply/divide unit).
//   - Default word width (ones' complement, MSB = sign).
//   - State encoding of the multiply/divide sequencer.
// No ports (package).
// -----------------------------------------------------------------------------
package agc_pkg;

   localparam int AGC_WIDTH = 15;

   localparam logic [2:0] ALU_AD   = 3'd0;
   localparam logic [2:0] ALU_SU   = 3'd1;
   localparam logic [2:0] ALU_MASK = 3'd2;
   localparam logic [2:0] ALU_MP0  = 3'd3;
   localparam logic [2:0] ALU_MP1  = 3'd4;
   localparam logic [2:0] ALU_DV0  = 3'd5;
   localparam logic [2:0] ALU_DV1  = 3'd6;

   typedef enum logic [2:0] {
      MD_IDLE = 3'd0,
      MD_LOAD = 3'd1,
      MD_ITER = 3'd2,
      MD_SIGN = 3'd3,
      MD_DONE = 3'd4
   } muldiv_state_t;

endpackage

// File: rtl/agc_muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// agc_muldiv_unit_if : request/response bundle between the AGC controller
// (master) and the multiply/divide unit (slave).
//   start   : one-cycle request strobe            (master -> slave)
//   alu_op  : op code sampled with start           (master -> slave)
//   x_in    : multiplicand / divisor               (master -> slave)
//   y_in    : multiplier / dividend upper word A   (master -> slave)
//   l_in    : dividend lower word L                (master -> slave)
//   busy    : operation in progress                (slave -> master)
//   done    : one-cycle completion pulse           (slave -> master)
//   ovf     : divide fault flag                    (slave -> master)
//   hi_out  : product upper word / quotient        (slave -> master)
//   lo_out  : product lower word / remainder       (slave -> master)
// -----------------------------------------------------------------------------
interface agc_muldiv_unit_if
   import agc_pkg::*;
#(
   parameter int WIDTH = AGC_WIDTH
);
   logic             start;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] x_in;
   logic [WIDTH-1:0] y_in;
   logic [WIDTH-1:0] l_in;
   logic             busy;
   logic             done;
   logic             ovf;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   modport master (
      output start, alu_op, x_in, y_in, l_in,
      input  busy, done, ovf, hi_out, lo_out
   );

   modport slave (
      input  start, alu_op, x_in, y_in, l_in,
      output busy, done, ovf, hi_out, lo_out
   );
endinterface

// File: rtl/agc_muldiv_unit_ones_comp_mag.sv
// -----------------------------------------------------------------------------
// ones_comp_mag : splits a ones' complement word into sign and magnitude.
//   i_word : WIDTH-bit ones' complement word
//   o_sign : sign bit (1 = negative)
//   o_mag  : WIDTH-1 bit magnitude; a negative word's magnitude is its
//            bitwise inverse, so both zeros (+0 and -0) give magnitude 0.
// Purely combinational.
// -----------------------------------------------------------------------------
module ones_comp_mag #(
   parameter int WIDTH = 15
) (
   input  logic [WIDTH-1:0] i_word,
   output logic             o_sign,
   output logic [WIDTH-2:0] o_mag
);
   assign o_sign = i_word[WIDTH-1];
   assign o_mag  = i_word[WIDTH-1] ? ~i_word[WIDTH-2:0] : i_word[WIDTH-2:0];
endmodule

// File: rtl/agc_muldiv_unit.sv
// -----------------------------------------------------------------------------
// agc_muldiv_unit : iterative ones' complement multiply / divide for the AGC.
//   MP0 (alu_op 3): shift-add product of x_in * y_in, hi/lo magnitude words.
//   DV0 (alu_op 5): restoring divide of {A=y_in, L=l_in} by x_in,
//                   hi = quotient, lo = remainder; ovf on divide fault.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset (aborts any operation)
//   io_bus : agc_muldiv_unit_if.slave (start/alu_op/operands in,
//            busy/done/ovf/hi_out/lo_out out)
// Optional build macro MULDIV_NEG_ZERO_NORM_EN: when defined, a result
// word equal to -0 (all ones) is rewritten to +0 in the SIGN state.
// -----------------------------------------------------------------------------
module agc_muldiv_unit
   import agc_pkg::*;
#(
   parameter int WIDTH = AGC_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   agc_muldiv_unit_if.slave      io_bus
);
   localparam int M  = WIDTH - 1;
   localparam int CW = $clog2(WIDTH);

   muldiv_state_t     r_state, w_state_nxt;
   logic              r_is_div;
   logic [WIDTH-1:0]  r_x, r_y, r_l;
   logic [M-1:0]      r_hi, r_lo;
   logic [CW-1:0]     r_cnt;
   logic              r_done, r_ovf;
   logic [WIDTH-1:0]  r_hi_out, r_lo_out;

   logic              w_sx, w_sy, w_sl;
   logic [M-1:0]      w_mx, w_my, w_ml;
   logic              w_accept, w_fault;
   logic [M-1:0]      w_mp_add;
   logic [M:0]        w_mp_sum;
   logic [M:0]        w_dv_shift;
   logic [M-1:0]      w_dv_diff;
   logic              w_dv_ge;

   // Ones' complement word from sign and magnitude; a negative word is the
   // inverse of the zero-extended magnitude.
   function automatic logic [WIDTH-1:0] f_sign(input logic s, input logic [M-1:0] mag);
      return s ? ~{1'b0, mag} : {1'b0, mag};
   endfunction

   function automatic logic [WIDTH-1:0] f_norm(input logic [WIDTH-1:0] w);
`ifdef MULDIV_NEG_ZERO_NORM_EN
      return (&w) ? '0 : w;
`else
      return w;
`endif
   endfunction

   ones_comp_mag #(.WIDTH(WIDTH)) u_mag_x (.i_word(r_x), .o_sign(w_sx), .o_mag(w_mx));
   ones_comp_mag #(.WIDTH(WIDTH)) u_mag_y (.i_word(r_y), .o_sign(w_sy), .o_mag(w_my));
   ones_comp_mag #(.WIDTH(WIDTH)) u_mag_l (.i_word(r_l), .o_sign(w_sl), .o_mag(w_ml));

   assign w_accept = (r_state == MD_IDLE) && io_bus.start &&
                     ((io_bus.alu_op == ALU_MP0) || (io_bus.alu_op == ALU_DV0));
   // The quotient only fits WIDTH-1 bits when |A| < |divisor|.
   assign w_fault  = r_is_div && ((w_mx == '0) || (w_my >= w_mx));

   // Multiply step: conditionally add |x| to the upper half, then shift right.
   assign w_mp_add = r_lo[0] ? w_mx : '0;
   assign w_mp_sum = {1'b0, r_hi} + {1'b0, w_mp_add};

   // Divide step: shift the partial remainder left and try subtracting |x|.
   // The difference is only kept when it is below |x|, so M bits suffice.
   assign w_dv_shift = {r_hi, r_lo[M-1]};
   assign w_dv_ge    = (w_dv_shift >= {1'b0, w_mx});
   assign w_dv_diff  = w_dv_shift[M-1:0] - w_mx;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MD_IDLE: if (w_accept) w_state_nxt = MD_LOAD;
         MD_LOAD: w_state_nxt = w_fault ? MD_DONE : MD_ITER;
         MD_ITER: if (r_cnt == '0) w_state_nxt = MD_SIGN;
         MD_SIGN: w_state_nxt = MD_DONE;
         MD_DONE: w_state_nxt = MD_IDLE;
         default: w_state_nxt = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= MD_IDLE;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_hi_out <= '0;
         r_lo_out <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (r_state == MD_DONE);
         if (w_accept) r_ovf <= 1'b0;
         if ((r_state == MD_LOAD) && w_fault) begin
            r_ovf    <= 1'b1;
            r_hi_out <= f_sign(w_sx ^ w_sy, {M{1'b1}});
            // Re-assembling sign and magnitude gives back l_in bit for bit.
            r_lo_out <= f_sign(w_sl, w_ml);
         end
         if (r_state == MD_SIGN) begin
            if (r_is_div) begin
               r_hi_out <= f_norm(f_sign(w_sy ^ w_sx, r_lo));
               r_lo_out <= f_norm(f_sign(w_sy, r_hi));
            end else begin
               r_hi_out <= f_norm(f_sign(w_sx ^ w_sy, r_hi));
               r_lo_out <= f_norm(f_sign(w_sx ^ w_sy, r_lo));
            end
         end
      end
   end

   // Datapath registers carry no reset; the state machine qualifies them.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_is_div <= (io_bus.alu_op == ALU_DV0);
         r_x      <= io_bus.x_in;
         r_y      <= io_bus.y_in;
         r_l      <= io_bus.l_in;
      end
      if (r_state == MD_LOAD) begin
         r_hi  <= r_is_div ? w_my : '0;
         r_lo  <= r_is_div ? w_ml : w_my;
         r_cnt <= CW'(M - 1);
      end else if (r_state == MD_ITER) begin
         r_cnt <= r_cnt - CW'(1);
         if (r_is_div) begin
            r_hi <= w_dv_ge ? w_dv_diff : w_dv_shift[M-1:0];
            r_lo <= {r_lo[M-2:0], w_dv_ge};
         end else begin
            r_hi <= w_mp_sum[M:1];
            r_lo <= {w_mp_sum[0], r_lo[M-1:1]};
         end
      end
   end

   assign io_bus.busy   = (r_state != MD_IDLE);
   assign io_bus.done   = r_done;
   assign io_bus.ovf    = r_ovf;
   assign io_bus.hi_out = r_hi_out;
   assign io_bus.lo_out = r_lo_out;
endmodule

// File: tb/tb_agc_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_agc_muldiv_unit : directed bench for agc_muldiv_unit (WIDTH = 15).
// Edges are counted from the clock edge that samples start (edge 0).
// -----------------------------------------------------------------------------
module tb_agc_muldiv_unit;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   agc_muldiv_unit_if #(.WIDTH(15)) bus ();

   agc_muldiv_unit #(.WIDTH(15)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request and watch 22 edges. Optionally pulse a DV0 start
   // while busy (after edge inj). Operands are scrambled after the start
   // cycle since the unit must have registered them.
   task automatic run_op(input logic [2:0] op, input logic [14:0] x,
                         input logic [14:0] y, input logic [14:0] l,
                         input int inj, output int done_edge,
                         output int ndone, output logic busy1);
      done_edge = -1;
      ndone     = 0;
      busy1     = 1'b0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.alu_op = op;
      bus.x_in   = x;
      bus.y_in   = y;
      bus.l_in   = l;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.x_in  = 15'h2AAA;
      bus.y_in  = 15'h5555;
      bus.l_in  = 15'h0F0F;
      for (int n = 1; n <= 22; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) busy1 = bus.busy;
         if (bus.done) begin
            ndone++;
            if (done_edge < 0) done_edge = n;
         end
         if (inj > 0 && n == inj) begin
            bus.start  = 1'b1;
            bus.alu_op = 3'd5;
         end else begin
            bus.start = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.alu_op = 3'd0;
      bus.x_in   = '0;
      bus.y_in   = '0;
      bus.l_in   = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
      checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
      checks++; if (bus.hi_out !== 15'h0000) begin failures++; $display("FAIL reset_hi got=%h want=0000", bus.hi_out); end
      checks++; if (bus.lo_out !== 15'h0000) begin failures++; $display("FAIL reset_lo got=%h want=0000", bus.lo_out); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_mp_neg();
      int de, nd; logic b1;
      logic [14:0] exp_hi;
`ifdef MULDIV_NEG_ZERO_NORM_EN
      exp_hi = 15'h0000;
`else
      exp_hi = 15'h7FFF;
`endif
      run_op(3'd3, 15'h0003, 15'h7FFC, 15'h0000, 0, de, nd, b1);
      checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL mp_neg_busy1 got=%b want=1", b1); end
      checks++; if (de != 17) begin failures++; $display("FAIL mp_neg_done_edge got=%0d want=17", de); end
      checks++; if (nd != 1) begin failures++; $display("FAIL mp_neg_ndone got=%0d want=1", nd); end
      checks++; if (bus.hi_out !== exp_hi) begin failures++; $display("FAIL mp_neg_hi got=%h want=%h", bus.hi_out, exp_hi); end
      checks++; if (bus.lo_out !== 15'h7FF6) begin failures++; $display("FAIL mp_neg_lo got=%h want=7ff6", bus.lo_out); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mp_neg_busy_end got=%b want=0", bus.busy); end
   endtask

   task automatic test_mp_max();
      int de, nd; logic b1;
      run_op(3'd3, 15'h3FFF, 15'h3FFF, 15'h0000, 0, de, nd, b1);
      checks++; if (de != 17) begin failures++; $display("FAIL mp_max_done_edge got=%0d want=17", de); end
      checks++; if (bus.hi_out !== 15'h3FFE) begin failures++; $display("FAIL mp_max_hi got=%h want=3ffe", bus.hi_out); end
      checks++; if (bus.lo_out !== 15'h0001) begin failures++; $display("FAIL mp_max_lo got=%h want=0001", bus.lo_out); end
      checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL mp_max_ovf got=%b want=0", bus.ovf); end
   endtask

   task automatic test_dv_fault();
      int de, nd; logic b1;
      run_op(3'd5, 15'h0003, 15'h0005, 15'h1234, 0, de, nd, b1);
      checks++; if (de != 2) begin failures++; $display("FAIL dv_fault_done_edge got=%0d want=2", de); end
      checks++; if (nd != 1) begin failures++; $display("FAIL dv_fault_ndone got=%0d want=1", nd); end
      checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL dv_fault_ovf got=%b want=1", bus.ovf); end
      checks++; if (bus.hi_out !== 15'h3FFF) begin failures++; $display("FAIL dv_fault_hi got=%h want=3fff", bus.hi_out); end
      checks++; if (bus.lo_out !== 15'h1234) begin failures++; $display("FAIL dv_fault_lo got=%h want=1234", bus.lo_out); end
   endtask

   task automatic test_dv();
      int de, nd; logic b1;
      run_op(3'd5, 15'h0004, 15'h0001, 15'h0000, 0, de, nd, b1);
      checks++; if (de != 17) begin failures++; $display("FAIL dv_pos_done_edge got=%0d want=17", de); end
      checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL dv_pos_ovf got=%b want=0", bus.ovf); end
      checks++; if (bus.hi_out !== 15'h1000) begin failures++; $display("FAIL dv_pos_hi got=%h want=1000", bus.hi_out); end
      checks++; if (bus.lo_out !== 15'h0000) begin failures++; $display("FAIL dv_pos_lo got=%h want=0000", bus.lo_out); end
      run_op(3'd5, 15'h7FFB, 15'h0001, 15'h0000, 0, de, nd, b1);
      checks++; if (bus.hi_out !== 15'h6FFF) begin failures++; $display("FAIL dv_negdiv_hi got=%h want=6fff", bus.hi_out); end
      checks++; if (bus.lo_out !== 15'h0000) begin failures++; $display("FAIL dv_negdiv_lo got=%h want=0000", bus.lo_out); end
      // -16389 / 4 : quotient -4097, remainder -1
      run_op(3'd5, 15'h0004, 15'h7FFE, 15'h0005, 0, de, nd, b1);
      checks++; if (bus.hi_out !== 15'h6FFE) begin failures++; $display("FAIL dv_negdvd_hi got=%h want=6ffe", bus.hi_out); end
      checks++; if (bus.lo_out !== 15'h7FFE) begin failures++; $display("FAIL dv_negdvd_lo got=%h want=7ffe", bus.lo_out); end
   endtask

   task automatic test_back_to_back();
      int de, nd; logic b1;
      run_op(3'd3, 15'h0002, 15'h0005, 15'h0000, 4, de, nd, b1);
      checks++; if (de != 17) begin failures++; $display("FAIL b2b_done_edge got=%0d want=17", de); end
      checks++; if (nd != 1) begin failures++; $display("FAIL b2b_ndone got=%0d want=1", nd); end
      checks++; if (bus.hi_out !== 15'h0000) begin failures++; $display("FAIL b2b_hi got=%h want=0000", bus.hi_out); end
      checks++; if (bus.lo_out !== 15'h000A) begin failures++; $display("FAIL b2b_lo got=%h want=000a", bus.lo_out); end
   endtask

   task automatic test_bad_op();
      logic saw_busy, saw_done;
      saw_busy = 1'b0;
      saw_done = 1'b0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.alu_op = 3'd0;
      bus.x_in   = 15'h0003;
      bus.y_in   = 15'h0003;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (bus.busy) saw_busy = 1'b1;
         if (bus.done) saw_done = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++; if (saw_busy !== 1'b0) begin failures++; $display("FAIL badop_busy got=%b want=0", saw_busy); end
      checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL badop_done got=%b want=0", saw_done); end
   endtask

   task automatic test_reset_mid();
      int de, nd; logic b1;
      logic saw_done;
      saw_done = 1'b0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.alu_op = 3'd3;
      bus.x_in   = 15'h0007;
      bus.y_in   = 15'h0009;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
      checks++; if (bus.hi_out !== 15'h0000) begin failures++; $display("FAIL rstmid_hi got=%h want=0000", bus.hi_out); end
      checks++; if (bus.lo_out !== 15'h0000) begin failures++; $display("FAIL rstmid_lo got=%h want=0000", bus.lo_out); end
      rst = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (bus.done) saw_done = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b want=0", saw_done); end
      run_op(3'd3, 15'h0003, 15'h0005, 15'h0000, 0, de, nd, b1);
      checks++; if (de != 17) begin failures++; $display("FAIL rstmid_next_edge got=%0d want=17", de); end
      checks++; if (bus.lo_out !== 15'h000F) begin failures++; $display("FAIL rstmid_next_lo got=%h want=000f", bus.lo_out); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_mp_neg();
      test_mp_max();
      test_dv_fault();
      test_dv();
      test_back_to_back();
      test_bad_op();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
